// File: rtl/start_pulse_gen.sv
// -----------------------------------------------------------------------------
// start_pulse_gen
//
// Multi-channel trigger-to-pulse generator. Each channel watches its trigger
// level for a selected edge. On that edge it emits a start pulse PULSE_W clk
// cycles wide. The channel then waits HOLDOFF cycles before it re-arms. Any
// edge that arrives while the channel is busy is dropped, and the drop is
// recorded in a sticky per-channel overrun flag.
//
// Parameters
//   CH           number of independent channels (>= 1)
//   PULSE_W      start pulse length in clk cycles (>= 1)
//   HOLDOFF      re-arm delay after the pulse ends, in clk cycles (>= 0)
//   SYNC_STAGES  flip-flop synchroniser depth on trig (0..3); 0 = trig is
//                already synchronous to clk
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   mode [1:0]   edge select shared by all channels:
//                00 rise, 01 fall, 10 both, 11 disabled
//   trig [CH]    per-channel trigger level
//   clr_overrun  synchronous clear of every overrun flag (a set in the
//                same cycle wins)
//   start [CH]   per-channel start pulse, decoded from registered state
//   busy [CH]    channel is in PULSE or HOLD
//   overrun [CH] sticky flag: an edge was dropped because the channel was busy
// -----------------------------------------------------------------------------
module start_pulse_gen #(
  parameter int CH          = 4,
  parameter int PULSE_W     = 1,
  parameter int HOLDOFF     = 0,
  parameter int SYNC_STAGES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] trig,
  input  logic          clr_overrun,
  output logic [CH-1:0] start,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] overrun
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int CNT_MAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  // HOLD is never entered when HOLDOFF is 0. The guard only keeps the
  // constant from going negative.
  localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  // ---------------------------------------------------------------------------
  // Input synchroniser: ts is trig delayed by SYNC_STAGES flops.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] ts;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign ts = trig;
  end else begin : g_sync
    logic [CH-1:0] sync_q [SYNC_STAGES];

    // NOTE: every stage is reset to 0. This is a short flop chain and not a
    // RAM, so the reset costs nothing. It also means a trigger held high
    // through reset is seen as a fresh rising edge after release.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
        sync_q[0] <= trig;
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
    end

    assign ts = sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Edge detection. prev follows ts every cycle, whatever the channel state.
  // Its reset value of 0 keeps the old level-to-pulse behaviour when trig
  // is already high at reset release.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] prev_q;

  // NOTE: non-blocking assignments for all clocked state. Every flop then
  // samples the values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= ts;
  end

  logic [CH-1:0] rise, fall, evt;

  always_comb begin
    rise = ts & ~prev_q;
    fall = ~ts & prev_q;
    case (mode)
      MODE_RISE: evt = rise;
      MODE_FALL: evt = fall;
      MODE_BOTH: evt = rise | fall;
      default:   evt = '0;   // 11: disabled, no events and no overruns
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel FSM: IDLE -> PULSE (PULSE_W cycles) -> HOLD (HOLDOFF cycles)
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q [CH];
  logic [1:0]    state_d [CH];
  logic [CW-1:0] cnt_q   [CH];
  logic [CW-1:0] cnt_d   [CH];

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: each path starts from "hold current value". This means no
      // branch can leave a signal unassigned and infer a latch.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (evt[i]) begin
            state_d[i] = ST_PULSE;
            cnt_d[i]   = '0;
          end
        end
        ST_PULSE: begin
          if (cnt_q[i] == PULSE_LAST) begin
            cnt_d[i]   = '0;
            state_d[i] = (HOLDOFF > 0) ? ST_HOLD : ST_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q[i] == HOLD_LAST) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and sticky overrun
  // ---------------------------------------------------------------------------
  logic [CH-1:0] busy_int;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      start[i]    = (state_q[i] == ST_PULSE);
      busy_int[i] = (state_q[i] != ST_IDLE);
    end
  end

  assign busy = busy_int;

  // A dropped event is never queued. It only leaves a mark here. The set term
  // is ORed in after the clear, so a set in the same cycle as a clear wins.
  logic [CH-1:0] overrun_q;
  logic [CH-1:0] ovr_set;

  assign ovr_set = evt & busy_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun_q <= '0;
    else        overrun_q <= (overrun_q & ~{CH{clr_overrun}}) | ovr_set;
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_start_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_start_pulse_gen
//
// Four instances of start_pulse_gen, each with a different parameter set:
//   dut 0: PULSE_W=1, HOLDOFF=0, SYNC_STAGES=0
//   dut 1: PULSE_W=3, HOLDOFF=2, SYNC_STAGES=0
//   dut 2: PULSE_W=4, HOLDOFF=0, SYNC_STAGES=2
//   dut 3: PULSE_W=4, HOLDOFF=0, SYNC_STAGES=0
// The stimulus drives inputs on the falling edge. For each cycle it pushes the
// hand-computed outputs expected after the next rising edge. A monitor pops
// one entry 1 time unit after every rising edge and compares the outputs of
// the named instance.
// -----------------------------------------------------------------------------
module tb_start_pulse_gen;

  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] trig_v    [NDUT];
  logic [1:0] mode_v    [NDUT];
  logic       clr_v     [NDUT];
  logic [3:0] start_v   [NDUT];
  logic [3:0] busy_v    [NDUT];
  logic [3:0] overrun_v [NDUT];

  always #5 clk = ~clk;

  start_pulse_gen #(.CH(4), .PULSE_W(1), .HOLDOFF(0), .SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mode(mode_v[0]), .trig(trig_v[0]),
    .clr_overrun(clr_v[0]), .start(start_v[0]), .busy(busy_v[0]),
    .overrun(overrun_v[0]));

  start_pulse_gen #(.CH(4), .PULSE_W(3), .HOLDOFF(2), .SYNC_STAGES(0)) u_dut1 (
    .clk(clk), .reset(reset), .mode(mode_v[1]), .trig(trig_v[1]),
    .clr_overrun(clr_v[1]), .start(start_v[1]), .busy(busy_v[1]),
    .overrun(overrun_v[1]));

  start_pulse_gen #(.CH(4), .PULSE_W(4), .HOLDOFF(0), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .mode(mode_v[2]), .trig(trig_v[2]),
    .clr_overrun(clr_v[2]), .start(start_v[2]), .busy(busy_v[2]),
    .overrun(overrun_v[2]));

  start_pulse_gen #(.CH(4), .PULSE_W(4), .HOLDOFF(0), .SYNC_STAGES(0)) u_dut3 (
    .clk(clk), .reset(reset), .mode(mode_v[3]), .trig(trig_v[3]),
    .clr_overrun(clr_v[3]), .start(start_v[3]), .busy(busy_v[3]),
    .overrun(overrun_v[3]));

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int         dut;
    int         row;
    logic [3:0] s;
    logic [3:0] b;
    logic [3:0] o;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row_id  = 0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle. The entry describes the outputs
  // after the rising edge that has just passed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("dut%0d row%0d start", e.dut, e.row),   start_v[e.dut],   e.s);
        check($sformatf("dut%0d row%0d busy", e.dut, e.row),    busy_v[e.dut],    e.b);
        check($sformatf("dut%0d row%0d overrun", e.dut, e.row), overrun_v[e.dut], e.o);
      end
    end
  end

  // One stimulus cycle: drive instance d (plus the shared reset) on the
  // falling edge, and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input int d, input logic [3:0] tr,
                     input logic [1:0] md, input logic clr,
                     input logic [3:0] es, input logic [3:0] eb, input logic [3:0] eo);
    exp_t e;
    @(negedge clk);
    reset     = r;
    trig_v[d] = tr;
    mode_v[d] = md;
    clr_v[d]  = clr;
    e.dut = d; e.row = row_id; e.s = es; e.b = eb; e.o = eo;
    sb.push_back(e);
    row_id++;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      trig_v[i] = 4'b0000;
      mode_v[i] = 2'b00;
      clr_v[i]  = 1'b0;
    end

    // Reset state of every instance. dut0 trig[3] is held high through reset.
    cyc(0, 0, 4'b1000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(0, 1, 4'b0000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(0, 2, 4'b0000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(0, 3, 4'b0000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);

    // Release: exactly one pulse on dut0 ch3 at the first edge.
    cyc(1, 0, 4'b1000, 2'b00, 0, 4'b1000, 4'b1000, 4'b0000);
    cyc(1, 0, 4'b1000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 0, 4'b1000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);

    // dut0: raise trig[0] and hold it for 10 cycles. One 1-cycle pulse only.
    cyc(1, 0, 4'b1001, 2'b00, 0, 4'b0001, 4'b0001, 4'b0000);
    for (int k = 0; k < 9; k++)
      cyc(1, 0, 4'b1001, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    // The falling edges are ignored in rise mode.
    cyc(1, 0, 4'b0000, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);

    // dut0, both-edge mode, HOLDOFF=0: a fall in the last PULSE cycle is
    // dropped. A rise in the first IDLE cycle is accepted (1-cycle gap).
    cyc(1, 0, 4'b0001, 2'b10, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 0, 4'b0000, 2'b10, 0, 4'b0000, 4'b0000, 4'b0001);
    cyc(1, 0, 4'b0001, 2'b10, 0, 4'b0001, 4'b0001, 4'b0001);
    cyc(1, 0, 4'b0001, 2'b10, 1, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 0, 4'b0000, 2'b11, 0, 4'b0000, 4'b0000, 4'b0000);

    // dut1 (PULSE_W=3, HOLDOFF=2), both edges: 1-cycle trig[1] pulse.
    cyc(1, 1, 4'b0010, 2'b10, 0, 4'b0010, 4'b0010, 4'b0000);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0010, 4'b0010, 4'b0010);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0010, 4'b0010, 4'b0010);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0010, 4'b0010);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0010, 4'b0010);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0000, 4'b0010);
    cyc(1, 1, 4'b0000, 2'b10, 1, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0000, 4'b0000);
    // Overrun set and clear in the same cycle: the set wins.
    cyc(1, 1, 4'b0001, 2'b10, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 1, 4'b0000, 2'b10, 1, 4'b0001, 4'b0001, 4'b0001);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0001, 4'b0001, 4'b0001);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0001, 4'b0001);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0001, 4'b0001);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0000, 4'b0001);
    cyc(1, 1, 4'b0000, 2'b10, 1, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 1, 4'b0000, 2'b10, 0, 4'b0000, 4'b0000, 4'b0000);

    // dut2 (SYNC_STAGES=2, PULSE_W=4), fall mode: the rise never fires.
    cyc(1, 2, 4'b0100, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 2, 4'b0100, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 2, 4'b0100, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 2, 4'b0100, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    // Drop trig[2] before edge k. The pulse covers edges k+2 .. k+5.
    cyc(1, 2, 4'b0000, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 2, 4'b0000, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++)
      cyc(1, 2, 4'b0000, 2'b01, 0, 4'b0100, 4'b0100, 4'b0000);
    cyc(1, 2, 4'b0000, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 2, 4'b0000, 2'b01, 0, 4'b0000, 4'b0000, 4'b0000);

    // dut3 (PULSE_W=4): reset asserted in pulse cycle 2 drops start at once.
    cyc(1, 3, 4'b0001, 2'b00, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 3, 4'b0001, 2'b00, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 3, 4'b0001, 2'b00, 0, 4'b0001, 4'b0001, 4'b0000);
    @(posedge clk);
    #2;
    check("dut3 pre_reset start", start_v[3], 4'b0001);
    reset = 1'b0;
    #1;
    check("dut3 async_reset start", start_v[3], 4'b0000);
    check("dut3 async_reset busy", busy_v[3], 4'b0000);
    cyc(0, 3, 4'b0001, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(0, 3, 4'b0001, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    // Release with trig held high: prev was reset, so there is one new pulse.
    for (int k = 0; k < 4; k++)
      cyc(1, 3, 4'b0001, 2'b00, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 3, 4'b0001, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 3, 4'b0001, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);

    // dut1: mode 11 during a ch0 pulse while all trig toggle every cycle.
    cyc(1, 1, 4'b0001, 2'b00, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b11, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 1, 4'b0001, 2'b11, 0, 4'b0001, 4'b0001, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b11, 0, 4'b0000, 4'b0001, 4'b0000);
    cyc(1, 1, 4'b0001, 2'b11, 0, 4'b0000, 4'b0001, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b11, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 1, 4'b0001, 2'b11, 0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1, 1, 4'b0000, 2'b11, 0, 4'b0000, 4'b0000, 4'b0000);
    // Simultaneous rises on ch1..ch3 each fire independently.
    cyc(1, 1, 4'b1110, 2'b00, 0, 4'b1110, 4'b1110, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b00, 0, 4'b1110, 4'b1110, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b00, 0, 4'b1110, 4'b1110, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b00, 0, 4'b0000, 4'b1110, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b00, 0, 4'b0000, 4'b1110, 4'b0000);
    cyc(1, 1, 4'b1110, 2'b00, 0, 4'b0000, 4'b0000, 4'b0000);

    // Let the monitor drain the scoreboard, with a bound on the wait.
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/start_pulse_gen.md
Name: start_pulse_gen

Overview:
- Multi-channel trigger-to-pulse generator; the parametrised successor of the single-channel start one-shot.
- Each channel converts an edge on its trigger input into a start pulse of programmable width.
- Adds a selectable edge mode, a re-arm holdoff, an optional input synchroniser and sticky overrun flags.
- Sits between control/handshake logic and the serial send engines; one channel per engine.

Parameters:
- CH, 4, number of independent channels (>=1).
- PULSE_W, 1, start pulse length in clk cycles (>=1).
- HOLDOFF, 0, cycles after pulse end before the channel re-arms (>=0).
- SYNC_STAGES, 0, flip-flop synchroniser stages on trig (0..3); 0 means trig is already synchronous.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  2  edge select, shared by all channels: 00 rise, 01 fall, 10 both, 11 disabled.
- trig  input  CH  per-channel trigger level (was start_send).
- clr_overrun  input  1  synchronous clear of all overrun flags.
- start  output  CH  per-channel start pulse.
- busy  output  CH  high while the channel is in PULSE or HOLD.
- overrun  output  CH  sticky flag: an event was dropped because the channel was busy.

Behaviour:
- Reset (reset=0, asynchronous): all channel states go to IDLE; counters 0; synchroniser and previous-value registers 0; start=0, busy=0, overrun=0.
- Synchroniser: ts = trig delayed by SYNC_STAGES registers. prev = ts registered every cycle in every state.
- Event detection, per channel:
  - rise = ts & ~prev; fall = ~ts & prev.
  - mode 00 → event=rise; 01 → fall; 10 → rise|fall; 11 → no event.
- Because prev resets to 0, a trig held high through reset release produces one rise event. This preserves the old level-to-pulse behaviour.
- Per-channel FSM states: IDLE, PULSE, HOLD.
  - IDLE: event → PULSE, cnt=0.
  - PULSE: cnt increments each cycle. When cnt==PULSE_W-1: go to HOLD with cnt=0 if HOLDOFF>0, else go to IDLE.
  - HOLD: cnt increments each cycle. When cnt==HOLDOFF-1 → IDLE.
- Outputs:
  - start[i] = (state==PULSE), decoded from the state register, so no combinational path from trig.
  - busy[i] = (state!=IDLE).
- Latency (SYNC_STAGES=0): trig changes before clock edge k; the edge is detected at edge k; start is high for cycles k..k+PULSE_W-1. Each synchroniser stage adds 1 cycle.
- Back-to-back: with HOLDOFF=0, an event detected in the last PULSE cycle is dropped (channel still busy). The earliest accepted event is in the first IDLE cycle, giving a minimum start low gap of 1 cycle.
- Overrun: an event while state!=IDLE sets overrun[i]; the event is discarded and never queued.
  - clr_overrun clears all flags.
  - A set and a clear in the same cycle: set wins.
- Mode change: takes effect on the next cycle's detection; in-flight PULSE/HOLD completes unchanged.
  - Entering mode 11 mid-pulse: the pulse and holdoff complete; no new events; no overrun set.
- Channels are fully independent; simultaneous events on several channels each fire.
- Counter width: $clog2(max(PULSE_W,HOLDOFF)+1).
- Reset asserted mid-pulse: start drops immediately (asynchronous); no pulse resumes after release unless a new event is detected.

Test Plan:
- CH=4, PULSE_W=1, mode=00, SYNC_STAGES=0: raise trig[0] and hold for 10 cycles → start[0] high exactly 1 cycle, the cycle after the edge; others 0; overrun=0.
- PULSE_W=3, HOLDOFF=2, mode=10: trig[1] pulse of 1-cycle width → rise gives start[1] high 3 cycles and busy 5 cycles. The fall event during PULSE is dropped and overrun[1]=1. Then pulse clr_overrun → overrun[1]=0.
- SYNC_STAGES=2, mode=01: drop trig[2] from 1 to 0 → start[2] asserts 3 cycles after the edge, for PULSE_W cycles; no pulse on the original rise if mode was 01 throughout.
- trig[3]=1 while reset=0, then release reset with mode=00 → exactly one start[3] pulse, at the first edge after release.
- PULSE_W=4: assert reset at pulse cycle 2 → start=0 asynchronously. Release reset with trig held high → one new pulse, since prev was reset to 0.
- mode=11 set during an active pulse on ch0 while all trig toggle every cycle → ch0 pulse completes; no further start; all overrun stay 0.
